// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, FSM states, ALU ops.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_RWB    = 4'd3,
        S_EXEC_I = 4'd4,
        S_IWB    = 4'd5,
        S_MEMADR = 4'd6,
        S_MEMRD  = 4'd7,
        S_MEMWB  = 4'd8,
        S_MEMWR  = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Modulo arithmetic throughout; slt compares as two's complement.
    function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_regfile.sv
// 32 x 32 register file: two asynchronous read ports, one synchronous write port, $0 hardwired to 0.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [32];

    // NOTE: the whole array is cleared on reset because software relies on zeroed registers;
    // this forces flops rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (we && waddr != 5'd0) begin
            // NOTE: non-blocking so every reader this edge sees the pre-write value.
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core sharing one ready-handshaked memory port for instructions and data.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       PC,
    output logic              halted,
    output logic [3:0]        state_dbg
);

    localparam state_e ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;

    state_e      state, next_state;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] rd_a, rd_b, imm_ext, addr_full;
    logic [5:0]  opcode, funct;
    alu_op_e     r_op;
    logic        funct_ok;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign imm_ext = sign_ext(ir[15:0]);

    mips_regfile u_regfile (
        .clk     (CLK),
        .rst_n   (Reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ir[25:21]),
        .raddr_b (ir[20:16]),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        r_op     = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_SLT:  r_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = S_EXEC_R;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_EXEC_I;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = ILLEGAL_NEXT;
                endcase
            end
            S_EXEC_R: next_state = funct_ok ? S_RWB : ILLEGAL_NEXT;
            S_EXEC_I: next_state = S_IWB;
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        case (state)
            S_RWB:   begin rf_we = 1'b1; rf_waddr = ir[15:11]; rf_wdata = alu_out; end
            S_IWB:   begin rf_we = 1'b1; rf_waddr = ir[20:16]; rf_wdata = alu_out; end
            S_MEMWB: begin rf_we = 1'b1; rf_waddr = ir[20:16]; rf_wdata = mdr;     end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            PC      <= RESET_PC;
            ir      <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    PC <= PC + 32'd4;
                end
                S_DECODE: begin
                    a_reg   <= rd_a;
                    b_reg   <= rd_b;
                    alu_out <= PC + (imm_ext << 2);
                end
                S_EXEC_R:           alu_out <= alu_calc(r_op, a_reg, b_reg);
                S_EXEC_I, S_MEMADR: alu_out <= a_reg + imm_ext;
                S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
                S_BRANCH: if (a_reg == b_reg) PC <= alu_out;
                S_JUMP:   PC <= {PC[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // Request is gated by Reset so an access in flight is dropped as soon as reset is asserted.
    // Everything else on the port comes from registered state, so it holds while mem_ready=0.
    assign mem_req   = Reset && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
    assign mem_we    = mem_req && (state == S_MEMWR);
    assign addr_full = (state == S_FETCH) ? PC : alu_out;
    assign mem_addr  = addr_full[ADDR_W-1:0] & ~ADDR_W'(3);
    assign mem_wdata = b_reg;
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench: one trapping core runs a program on a wait-state memory, a non-trapping core checks NOP-on-illegal.
module tb_mips_multicycle_core;
    import mips_pkg::*;

    logic        CLK;
    logic        Reset;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, PC;
    logic [3:0]  state_dbg;

    logic        mem_req2, mem_we2, halted2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2;
    logic [3:0]  state_dbg2;

    logic [31:0] mem  [128];
    logic [31:0] mem2 [4];

    int n_tests = 0;
    int n_fail  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_rdata  = mem[mem_addr[8:2]];
    assign mem_rdata2 = mem2[mem_addr2[3:2]];

    mips_multicycle_core dut (
        .CLK (CLK), .Reset (Reset),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .mem_ready (mem_ready),
        .PC (PC), .halted (halted), .state_dbg (state_dbg)
    );

    mips_multicycle_core #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
        .CLK (CLK), .Reset (Reset),
        .mem_req (mem_req2), .mem_we (mem_we2), .mem_addr (mem_addr2),
        .mem_wdata (mem_wdata2), .mem_rdata (mem_rdata2), .mem_ready (1'b1),
        .PC (pc2), .halted (halted2), .state_dbg (state_dbg2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: commit a completing store into the bench memory, then sample 1 unit after the edge.
    task automatic tick();
        logic        do_wr;
        logic [6:0]  idx;
        logic [31:0] d;
        #1;
        do_wr = ((mem_req && mem_we && mem_ready) === 1'b1);
        idx   = mem_addr[8:2];
        d     = mem_wdata;
        @(posedge CLK);
        if (do_wr) mem[idx] = d;
        #1;
    endtask

    task automatic run_instr(input logic [31:0] pc_exp, input int cpi, input string tag);
        int n;
        check({tag, " fetch_addr"}, mem_addr, pc_exp);
        check({tag, " fetch_req"}, {31'd0, mem_req}, 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (state_dbg != S_FETCH && state_dbg != S_HALT && n < 20);
        check({tag, " cycles"}, 32'(n), 32'(cpi));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        mem[0]  = 32'h2001_0005; // addi $1,$0,5
        mem[1]  = 32'h2002_FFFD; // addi $2,$0,-3
        mem[2]  = 32'h0022_1820; // add  $3,$1,$2
        mem[3]  = 32'h0041_202A; // slt  $4,$2,$1
        mem[4]  = 32'h1021_0002; // beq  $1,$1,+2
        mem[5]  = 32'hFC00_0000;
        mem[6]  = 32'hFC00_0000;
        mem[7]  = 32'hAC03_0080; // sw $3,0x80($0)
        mem[8]  = 32'hAC04_0084; // sw $4,0x84($0)
        mem[9]  = 32'hAC01_0008; // sw $1,8($0)
        mem[10] = 32'h8C05_0008; // lw $5,8($0)
        mem[11] = 32'hAC05_0088; // sw $5,0x88($0)
        mem[12] = 32'h1022_0005; // beq $1,$2,+5 (not taken)
        mem[13] = 32'h0800_0040; // j 0x40 -> 0x100
        mem[36] = 32'hDEAD_BEEF;
        mem[64] = 32'h8C07_0003; // lw $7,3($0)
        mem[65] = 32'hAC07_008E; // sw $7,0x8E($0)
        mem[66] = 32'h0021_0020; // add $0,$1,$1
        mem[67] = 32'hAC00_0090; // sw $0,0x90($0)
        mem[68] = 32'h0041_4022; // sub $8,$2,$1
        mem[69] = 32'hAC08_0094; // sw $8,0x94($0)
        mem[70] = 32'h0022_4824; // and $9,$1,$2
        mem[71] = 32'h0022_5025; // or  $10,$1,$2
        mem[72] = 32'hAC09_009C; // sw $9,0x9C($0)
        mem[73] = 32'hAC0A_00A0; // sw $10,0xA0($0)
        mem[74] = 32'hFC00_0000; // illegal opcode 0x3F
        mem2[0] = 32'hFC00_0000; // illegal opcode
        mem2[1] = 32'h0000_0000; // R-type with unknown funct 0
        mem2[2] = 32'h0800_0000; // j 0
        mem2[3] = 32'h0000_0000;

        Reset     = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        check("rst state", state_dbg, S_FETCH);
        check("rst pc", PC, 32'h0);
        check("rst req", {31'd0, mem_req}, 32'd0);
        check("rst we", {31'd0, mem_we}, 32'd0);
        check("rst halted", {31'd0, halted}, 32'd0);

        Reset = 1'b1;
        #1;
        check("fetch0 req", {31'd0, mem_req}, 32'd1);
        check("fetch0 we", {31'd0, mem_we}, 32'd0);
        check("fetch0 addr", mem_addr, 32'h0);
        tick();
        check("fetch0 pc", PC, 32'h4);
        check("fetch0 decode", state_dbg, S_DECODE);
        tick();
        check("addi1 exec", state_dbg, S_EXEC_I);
        check("nop core state", state_dbg2, S_FETCH);
        check("nop core addr", mem_addr2, 32'h4);
        check("nop core halted", {31'd0, halted2}, 32'd0);
        tick();
        check("addi1 wb", state_dbg, S_IWB);
        tick();

        run_instr(32'h04, 4, "addi2");
        run_instr(32'h08, 4, "add");
        run_instr(32'h0C, 4, "slt");
        run_instr(32'h10, 3, "beq taken");
        run_instr(32'h1C, 4, "sw r3");
        check("add result", mem[32], 32'd2);
        run_instr(32'h20, 4, "sw r4");
        check("slt result", mem[33], 32'd1);

        check("sw wait fetch", mem_addr, 32'h24);
        tick();
        tick();
        tick();
        check("sw wait state", state_dbg, S_MEMWR);
        mem_ready = 1'b0;
        #1;
        for (int w = 0; w < 3; w++) begin
            check("sw wait req", {31'd0, mem_req}, 32'd1);
            check("sw wait we", {31'd0, mem_we}, 32'd1);
            check("sw wait addr", mem_addr, 32'h8);
            check("sw wait data", mem_wdata, 32'd5);
            check("sw wait hold", state_dbg, S_MEMWR);
            tick();
        end
        check("sw no early write", mem[2], 32'h0022_1820);
        mem_ready = 1'b1;
        tick();
        check("sw done state", state_dbg, S_FETCH);
        check("sw word 8", mem[2], 32'd5);

        check("lw wait fetch", mem_addr, 32'h28);
        tick();
        tick();
        tick();
        check("lw wait state", state_dbg, S_MEMRD);
        mem_ready = 1'b0;
        #1;
        for (int w = 0; w < 3; w++) begin
            check("lw wait req", {31'd0, mem_req}, 32'd1);
            check("lw wait we", {31'd0, mem_we}, 32'd0);
            check("lw wait addr", mem_addr, 32'h8);
            check("lw wait hold", state_dbg, S_MEMRD);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("lw memwb", state_dbg, S_MEMWB);
        tick();
        run_instr(32'h2C, 4, "sw r5");
        check("lw result", mem[34], 32'd5);

        run_instr(32'h30, 3, "beq not taken");
        run_instr(32'h34, 3, "j");
        run_instr(32'h100, 5, "lw unaligned");

        check("sw unal fetch", mem_addr, 32'h104);
        tick();
        tick();
        tick();
        check("sw unal state", state_dbg, S_MEMWR);
        check("sw unal addr", mem_addr, 32'h8C);
        check("sw unal data", mem_wdata, 32'h2001_0005);
        tick();
        check("sw unal word", mem[35], 32'h2001_0005);

        run_instr(32'h108, 4, "add r0");
        run_instr(32'h10C, 4, "sw r0");
        check("r0 reads zero", mem[36], 32'd0);
        run_instr(32'h110, 4, "sub");
        run_instr(32'h114, 4, "sw r8");
        check("sub result", mem[37], 32'hFFFF_FFF8);
        run_instr(32'h118, 4, "and");
        run_instr(32'h11C, 4, "or");
        run_instr(32'h120, 4, "sw r9");
        check("and result", mem[39], 32'd5);
        run_instr(32'h124, 4, "sw r10");
        check("or result", mem[40], 32'hFFFF_FFFD);

        run_instr(32'h128, 2, "illegal");
        check("halt state", state_dbg, S_HALT);
        check("halt pc", PC, 32'h12C);
        for (int w = 0; w < 3; w++) begin
            check("halt halted", {31'd0, halted}, 32'd1);
            check("halt no req", {31'd0, mem_req}, 32'd0);
            tick();
        end
        check("nop core still running", {31'd0, halted2}, 32'd0);

        mem[0]  = 32'hAC01_0098; // sw $1,0x98($0)
        mem[38] = 32'hDEAD_BEEF;
        Reset = 1'b0;
        tick();
        tick();
        check("rst2 state", state_dbg, S_FETCH);
        check("rst2 halted", {31'd0, halted}, 32'd0);
        check("rst2 pc", PC, 32'h0);
        Reset = 1'b1;
        #1;
        check("rst2 fetch addr", mem_addr, 32'h0);
        tick();
        tick();
        tick();
        check("midacc state", state_dbg, S_MEMWR);
        check("midacc we", {31'd0, mem_we}, 32'd1);
        check("midacc addr", mem_addr, 32'h98);
        check("regs cleared", mem_wdata, 32'd0);
        mem_ready = 1'b0;
        #1;
        Reset = 1'b0;
        tick();
        check("midacc req drop", {31'd0, mem_req}, 32'd0);
        check("midacc state rst", state_dbg, S_FETCH);
        check("midacc no write", mem[38], 32'hDEAD_BEEF);
        Reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        run_instr(32'h0, 4, "sw after reset");
        check("post reset store", mem[38], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Next-generation MIPS core. A multi-cycle FSM replaces the single-cycle ControlUnit/DataPath pair. The core shares one instruction/data memory port with a ready handshake, so it tolerates wait-stated memory. It sits at the same level as the existing single-cycle top and supports the same ISA subset plus addi and an illegal-opcode halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
ADDR_W, 32, width of mem_addr; PC/ALU address bits above ADDR_W are dropped
TRAP_ON_ILLEGAL, 1, 1 = halt on unknown opcode/funct; 0 = treat it as a NOP

Ports:
CLK  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-low reset (0 = reset, sampled on the CLK rising edge)
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  ADDR_W  byte address; word-aligned by construction
mem_wdata  output  32  store data; valid while mem_req and mem_we are 1
mem_rdata  input  32  read data; valid in the cycle mem_ready=1
mem_ready  input  1  access completes in any cycle where mem_req and mem_ready are both 1
PC  output  32  architectural PC of the instruction in progress
halted  output  1  core stopped on an illegal instruction
state_dbg  output  4  current FSM state encoding

Behaviour:
- Reset (Reset=0 at a CLK edge):
  - State goes to FETCH; PC=RESET_PC; IR=0; halted=0; mem_req=0; mem_we=0.
  - Register file is cleared to 0.
  - Applies mid-access too: the pending request is abandoned and mem_req is 0 in the next cycle.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ready=1.
  - The FSM stays in the access state while mem_ready=0, for unbounded wait.
  - No combinational path from mem_ready to the mem_* outputs except mem_req deasserting on the next edge.
- States and transitions:
  - FETCH: req read at PC. On ready: IR<=mem_rdata, PC<=PC+4. Go to DECODE.
  - DECODE: read rs/rt into A/B. ALUOut<=PC+(signext(imm)<<2). Dispatch on opcode:
    - R-type -> EXEC_R
    - lw, sw -> MEMADR
    - beq -> BRANCH
    - addi -> EXEC_I
    - j -> JUMP
    - other -> HALT if TRAP_ON_ILLEGAL, else FETCH
  - EXEC_R: ALUOut<=A op B, op from funct: add 20h, sub 22h, and 24h, or 25h, slt 2Ah. Unknown funct follows the illegal-opcode rule. Next RWB.
  - RWB: rd<=ALUOut. Next FETCH.
  - EXEC_I: ALUOut<=A+signext(imm). Next IWB.
  - IWB: rt<=ALUOut. Next FETCH.
  - MEMADR: ALUOut<=A+signext(imm). lw -> MEMRD; sw -> MEMWR.
  - MEMRD: req read at ALUOut. On ready: MDR<=rdata. Next MEMWB.
  - MEMWB: rt<=MDR. Next FETCH.
  - MEMWR: req write at ALUOut, wdata=B. On ready -> FETCH.
  - BRANCH: if A==B then PC<=ALUOut. Next FETCH.
  - JUMP: PC<={PC[31:28], IR[25:0], 2'b00}. Next FETCH.
  - HALT: halted=1, mem_req=0. Held until reset.
- Register file:
  - Writes to register 0 are discarded; reads of register 0 return 0.
- Arithmetic:
  - 32-bit modulo; add/sub/addi do not trap on overflow.
  - slt is signed compare.
- Memory alignment:
  - Unaligned lw/sw addresses have bits [1:0] forced to 0 on mem_addr.
- CPI: R/addi 4, lw 5, sw 4, beq 3, j 3 (zero-wait memory).
- PC semantics: PC increments at fetch completion, so during execute PC = instr_addr+4. The PC output shows this register.

Decomposition:
- Package mips_pkg:
  - opcode constants: RTYPE 0, LW 23h, SW 2Bh, BEQ 04h, ADDI 08h, J 02h
  - funct constants
  - state enum (4-bit)
  - ALU op enum
- Natural sub-module: mips_regfile (2 async read ports, 1 sync write port, sync active-low clear).
- The ALU and the FSM live in the top.

Test Plan:
- Reset and first fetch: Reset=0 for 2 cycles, then 1; mem_ready=1 -> cycle 1 shows mem_req=1, mem_we=0, mem_addr=RESET_PC; PC=4 after fetch.
- R-type and addi: program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> $3=2, $4=1; each R-type takes 4 cycles.
- Load/store under wait states: sw $1,8($0) then lw $5,8($0); mem_ready held 0 for 3 cycles each -> mem_* outputs stable while waiting, memory word 8 = 5, $5=5.
- Control flow: beq $1,$1,+2 at 0x10 -> next fetch at 0x1C. j 0x40 -> next fetch at 0x100. Not-taken beq -> fetch at 0x14.
- Illegal opcode: 0x3F opcode with TRAP_ON_ILLEGAL=1 -> halted=1 and no further mem_req; with 0 -> next fetch at PC+4.
- Reset mid-access: assert Reset=0 during MEMWR with mem_ready=0 -> next cycle mem_req=0; after release, fetch from RESET_PC; registers read 0.
